ddr3_line_cache: RTL and testbench
==================================

Name: ddr3_line_cache

Overview:
- Direct-mapped, write-back line cache between the 32-bit word bus (CPU/system interconnect) and the 256-bit line interface of ddr3_ctrl.
- Converts word reads/writes into whole-line refills and write-backs.
- Serves hits locally with single-cycle latency, so DDR3 traffic occurs only on misses.

Parameters:
- LINES, 8, number of cache lines (power of two, >=2).
- IDX_W, $clog2(LINES), index width (derived, not overridden).

Ports:
- clk  input  1  system clock (same domain as ddr3_ctrl clk).
- rst  input  1  synchronous, active-high reset.
- addr_i  input  32  word-bus byte address; [1:0] ignored.
- data_i  input  32  write data.
- data_o  output  32  read data, valid while ack_o=1.
- we_i  input  1  write request, level, held until ack_o.
- rd_i  input  1  read request, level, held until ack_o.
- ack_o  output  1  one-cycle completion pulse.
- mem_addr_o  output  32  line address to ddr3_ctrl addr_i, line-aligned byte address ([4:0]=0).
- mem_data_o  output  256  write-back line to ddr3_ctrl data_i.
- mem_data_i  input  256  refill line from ddr3_ctrl data_o.
- mem_we_o  output  1  to ddr3_ctrl we_i.
- mem_rd_o  output  1  to ddr3_ctrl rd_i.
- mem_ack_i  input  1  from ddr3_ctrl ack_o.

Behaviour:
- Address split: word = addr_i[4:2], idx = addr_i[5+IDX_W-1:5], tag = addr_i[31:5+IDX_W].
- Word w occupies line bits [32w+31:32w].
- Per line: valid bit, dirty bit, tag, 256-bit data.
- Reset: all valid and dirty cleared; state IDLE; ack_o, mem_we_o, mem_rd_o = 0; data_o, mem_addr_o, mem_data_o = 0.
- States: IDLE, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - With we_i|rd_i: capture addr, data, op; we_i has priority if both are high.
  - Hit (valid & tag match): perform the access and go to RESPOND.
  - Miss, victim dirty: go to WRITEBACK.
  - Miss, victim clean or invalid: go to REFILL.
- WRITEBACK:
  - mem_we_o=1, mem_addr_o={victim tag, idx, 5'b0}, mem_data_o=victim line; all held stable until mem_ack_i.
  - On mem_ack_i: clear dirty, go to REFILL; mem_we_o low the following cycle.
- REFILL:
  - mem_rd_o=1, mem_addr_o={tag, idx, 5'b0}, held until mem_ack_i.
  - On mem_ack_i: store mem_data_i, valid=1, dirty=0, store tag, then perform the access and go to RESPOND.
- Access:
  - Read: data_o <= selected word.
  - Write: merge data_i into the selected word, dirty=1; data_o <= data_i.
- RESPOND: ack_o=1 for exactly one cycle, then IDLE. The requester drops its request in the cycle after ack_o.
- Hit latency: request seen in IDLE at edge N; ack_o high during cycle N+1.
- Miss latency: 1 + memory round trips + 1.
- mem_we_o and mem_rd_o are never high together. Each is deasserted in the cycle after mem_ack_i, giving at least one idle cycle between memory requests.
- Request changes while not in IDLE are ignored; the captured request is served.
- Reset mid-operation aborts immediately: memory strobes drop and dirty data is lost. Accepted; no flush port.
- A refill of a line whose write-back is in progress is not possible (single outstanding miss).

Decomposition:
- ddr3_cache_defs.vh holds constants:
  - LINE_W=256, WORD_W=32, WORD_SEL_W=3, LINE_OFF_W=5.
  - State encodings ST_IDLE/ST_WRITEBACK/ST_REFILL/ST_RESPOND.
- One sub-module: ddr3_cache_store, holding the LINES-entry tag/valid/dirty/data arrays.
  - Combinational read port: idx → {valid, dirty, tag, line}.
  - Write port: full-line write with tag/valid/dirty, or single-word merge.

Test Plan:
1. After reset, read 0x0000_0048 → mem_rd_o=1, mem_addr_o=0x40; model acks after 5 cycles with word2=0x1234_5678 → ack_o one cycle, data_o=0x1234_5678.
2. Write 0xDEAD_BEEF to 0x48, then read 0x48 → each ack_o exactly 1 cycle after the request, no mem_we_o/mem_rd_o, read data_o=0xDEAD_BEEF.
3. Read 0x148 (same idx 2, different tag, line dirty) → mem_we_o first with mem_addr_o=0x40 and mem_data_o[95:64]=0xDEAD_BEEF; then mem_rd_o with mem_addr_o=0x140; ack_o after the refill.
4. we_i=rd_i=1, addr 0x4C, data 0xA5A5_A5A5 → treated as write; later read of 0x4C returns 0xA5A5_A5A5.
5. Assert rst for 1 cycle during REFILL → next cycle mem_rd_o=0, ack_o=0; re-read of a previously hit address → misses (mem_rd_o=1).
6. mem_ack_i delayed 20 cycles → mem_addr_o/mem_data_o/strobe stable throughout, ack_o stays 0 until the refill completes.

Source files
------------

// File: rtl/ddr3_line_cache_pkg.sv
// ddr3_line_cache_pkg: shared constants, FSM states and word/line helpers for the DDR3 line cache.
package ddr3_line_cache_pkg;
    localparam int LINE_W     = 256;
    localparam int WORD_W     = 32;
    localparam int WORD_SEL_W = 3;
    localparam int LINE_OFF_W = 5;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITEBACK, ST_REFILL, ST_RESPOND} state_t;

    function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_SEL_W-1:0] sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction

    function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_SEL_W-1:0] sel,
                                                   input logic [WORD_W-1:0] word);
        logic [LINE_W-1:0] r;
        r = line;
        r[sel*WORD_W +: WORD_W] = word;
        return r;
    endfunction
endpackage

// File: rtl/ddr3_line_cache_store.sv
// ddr3_line_cache_store: per-line valid/dirty/tag/data arrays with a combinational read port
// and one write port that stores a whole line, optionally with one word merged in.
module ddr3_line_cache_store import ddr3_line_cache_pkg::*; #(
    parameter int LINES = 8,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 32 - LINE_OFF_W - IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_W-1:0]     rd_line,
    input  logic                  wr_en,
    input  logic                  wr_dirty,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [LINE_W-1:0]     wr_line,
    input  logic                  wr_word_en,
    input  logic [WORD_SEL_W-1:0] wr_word_sel,
    input  logic [WORD_W-1:0]     wr_word
);
    logic [LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    logic [LINE_W-1:0] merged;

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];
    assign merged   = wr_word_en ? put_word(wr_line, wr_word_sel, wr_word) : wr_line;

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_en) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Contents need no reset: valid gates every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx]  <= wr_tag;
            data_q[idx] <= merged;
        end
    end
endmodule

// File: rtl/ddr3_line_cache.sv
// ddr3_line_cache: direct-mapped write-back cache turning 32-bit word accesses into
// 256-bit line refills/write-backs towards ddr3_ctrl.
module ddr3_line_cache import ddr3_line_cache_pkg::*; #(
    parameter int LINES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    input  logic              we_i,
    input  logic              rd_i,
    output logic              ack_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_we_o,
    output logic              mem_rd_o,
    input  logic              mem_ack_i
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - LINE_OFF_W - IDX_W;

    state_t            state_q, state_d;
    logic [31:2]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, data_q, data_d, mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d;
    logic              op_we_q, op_we_d, ack_q, ack_d, mem_we_q, mem_we_d, mem_rd_q, mem_rd_d;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      in_tag, cur_tag, wr_tag;
    logic                  cur_valid, cur_dirty, wr_en, wr_dirty, wr_word_en;
    logic [LINE_W-1:0]     cur_line, wr_line;
    logic [WORD_SEL_W-1:0] wr_word_sel;
    logic [WORD_W-1:0]     wr_word;
    logic                  unused_ok;

    assign unused_ok = &{1'b0, addr_i[1:0]};
    assign in_tag    = addr_i[31:LINE_OFF_W+IDX_W];
    // In IDLE the lookup follows the live bus; afterwards the captured address.
    assign idx = (state_q == ST_IDLE) ? addr_i[LINE_OFF_W +: IDX_W] : addr_q[LINE_OFF_W +: IDX_W];

    ddr3_line_cache_store #(.LINES(LINES)) u_store (
        .clk(clk), .rst(rst), .idx(idx),
        .rd_valid(cur_valid), .rd_dirty(cur_dirty), .rd_tag(cur_tag), .rd_line(cur_line),
        .wr_en(wr_en), .wr_dirty(wr_dirty), .wr_tag(wr_tag), .wr_line(wr_line),
        .wr_word_en(wr_word_en), .wr_word_sel(wr_word_sel), .wr_word(wr_word)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_we_d     = op_we_q;
        ack_d       = 1'b0;
        data_d      = data_q;
        mem_we_d    = mem_we_q;
        mem_rd_d    = mem_rd_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        wr_en       = 1'b0;
        wr_dirty    = 1'b0;
        wr_tag      = cur_tag;
        wr_line     = cur_line;
        wr_word_en  = 1'b0;
        wr_word_sel = addr_q[4:2];
        wr_word     = wdata_q;
        case (state_q)
            ST_IDLE: if (we_i || rd_i) begin
                addr_d  = addr_i[31:2];
                wdata_d = data_i;
                op_we_d = we_i;
                if (cur_valid && cur_tag == in_tag) begin
                    wr_en       = we_i;
                    wr_dirty    = 1'b1;
                    wr_word_en  = we_i;
                    wr_word_sel = addr_i[4:2];
                    wr_word     = data_i;
                    data_d      = we_i ? data_i : get_word(cur_line, addr_i[4:2]);
                    ack_d       = 1'b1;
                    state_d     = ST_RESPOND;
                end else if (cur_valid && cur_dirty) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = {cur_tag, addr_i[LINE_OFF_W +: IDX_W], {LINE_OFF_W{1'b0}}};
                    mem_data_d = cur_line;
                    state_d    = ST_WRITEBACK;
                end else begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {addr_i[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
                    state_d    = ST_REFILL;
                end
            end
            ST_WRITEBACK: if (mem_ack_i) begin
                wr_en      = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = {addr_q[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
                state_d    = ST_REFILL;
            end
            // Read strobe rises one cycle after entry from WRITEBACK, leaving an idle gap.
            ST_REFILL: if (mem_rd_q && mem_ack_i) begin
                wr_en      = 1'b1;
                wr_tag     = addr_q[31:LINE_OFF_W+IDX_W];
                wr_line    = mem_data_i;
                wr_dirty   = op_we_q;
                wr_word_en = op_we_q;
                data_d     = op_we_q ? wdata_q : get_word(mem_data_i, addr_q[4:2]);
                mem_rd_d   = 1'b0;
                ack_d      = 1'b1;
                state_d    = ST_RESPOND;
            end else begin
                mem_rd_d = 1'b1;
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_we_q    <= 1'b0;
            ack_q      <= 1'b0;
            data_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_we_q    <= op_we_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            mem_we_q   <= mem_we_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign data_o     = data_q;
    assign ack_o      = ack_q;
    assign mem_we_o   = mem_we_q;
    assign mem_rd_o   = mem_rd_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
endmodule

// File: tb/tb_ddr3_line_cache.sv
// tb_ddr3_line_cache: directed and random accesses checked against a line-residency model
// and a lazily-filled DDR memory model that also answers the cache's line requests.
module tb_ddr3_line_cache;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr_i = '0, data_i = '0, data_o, mem_addr_o;
    logic         we_i = 1'b0, rd_i = 1'b0, ack_o, mem_we_o, mem_rd_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    ddr3_line_cache #(.LINES(8)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .we_i(we_i), .rd_i(rd_i), .ack_o(ack_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_we_o(mem_we_o),
        .mem_rd_o(mem_rd_o), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    logic [255:0] ddr [logic [26:0]];
    bit           m_vld   [8];
    bit           m_dirty [8];
    logic [26:0]  m_la    [8];
    logic [255:0] m_line  [8];

    int           mem_lat = 3;
    int           n_wb = 0, n_rf = 0;
    logic [31:0]  wb_addr = '0, rf_addr = '0;
    logic [255:0] wb_data = '0;
    bit           stable_ok = 1'b1, excl_ok = 1'b1;

    function automatic logic [255:0] ddr_line(input logic [26:0] la);
        logic [255:0] v;
        if (!ddr.exists(la)) begin
            for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
            ddr[la] = v;
        end
        return ddr[la];
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // DDR responder: acks each strobe after mem_lat cycles, records traffic and stability.
    initial begin
        int cnt;
        logic [31:0]  hold_addr;
        logic [255:0] hold_data;
        cnt = 0;
        hold_addr = '0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (mem_we_o && mem_rd_o) excl_ok = 1'b0;
            if (!(mem_we_o || mem_rd_o)) cnt = 0;
            else begin
                if (cnt == 0) begin
                    hold_addr = mem_addr_o;
                    hold_data = mem_data_o;
                end else if (mem_addr_o !== hold_addr || (mem_we_o && mem_data_o !== hold_data))
                    stable_ok = 1'b0;
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_ack_i = 1'b1;
                    cnt = 0;
                    if (mem_we_o) begin
                        n_wb++;
                        wb_addr = mem_addr_o;
                        wb_data = mem_data_o;
                        ddr[mem_addr_o[31:5]] = mem_data_o;
                    end else begin
                        n_rf++;
                        rf_addr = mem_addr_o;
                        mem_data_i = ddr_line(mem_addr_o[31:5]);
                    end
                end
            end
        end
    end

    task automatic access(input bit we, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input int lat);
        int          idx, cyc, wb0, rf0;
        logic [26:0] la, vla;
        logic [255:0] vline;
        logic [31:0] want;
        bit          hit, wb;
        la    = a[31:5];
        idx   = int'(a[7:5]);
        hit   = m_vld[idx] && m_la[idx] == la;
        wb    = !hit && m_vld[idx] && m_dirty[idx];
        vline = m_line[idx];
        vla   = m_la[idx];
        mem_lat = lat;
        wb0 = n_wb;
        rf0 = n_rf;
        @(negedge clk);
        we_i = we; rd_i = rd; addr_i = a; data_i = d;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!ack_o && cyc < 400);
        chk("ack_seen", ack_o, 1);
        if (!hit) begin
            m_line[idx]  = ddr_line(la);
            m_vld[idx]   = 1'b1;
            m_la[idx]    = la;
            m_dirty[idx] = 1'b0;
        end
        if (we) begin
            m_line[idx][a[4:2]*32 +: 32] = d;
            m_dirty[idx] = 1'b1;
            want = d;
        end else want = m_line[idx][a[4:2]*32 +: 32];
        chk("data_o", data_o, want);
        chk("wb_count", n_wb - wb0, wb ? 1 : 0);
        chk("rf_count", n_rf - rf0, hit ? 0 : 1);
        if (wb) begin
            chk("wb_addr", wb_addr, {vla, 5'b0});
            chk("wb_data", wb_data, vline);
            chk("latency_wb", cyc >= 2*lat + 2 && cyc <= 2*lat + 4, 1);
        end else chk("latency", cyc, hit ? 1 : lat + 1);
        if (!hit) chk("rf_addr", rf_addr, {la, 5'b0});
        @(posedge clk); #1;
        chk("ack_pulse", ack_o, 0);
        we_i = 1'b0; rd_i = 1'b0;
    endtask

    initial begin
        logic [255:0] l2;
        int w;
        for (int i = 0; i < 8; i++) begin
            m_vld[i] = 0; m_dirty[i] = 0; m_la[i] = '0; m_line[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_rd", mem_rd_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        @(negedge clk);
        rst = 1'b0;

        l2 = ddr_line(27'h2);
        l2[95:64] = 32'h1234_5678;
        ddr[27'h2] = l2;
        access(0, 1, 32'h48, 32'h0, 5);
        chk("t1_word", data_o, 32'h1234_5678);

        access(1, 0, 32'h48, 32'hDEAD_BEEF, 3);
        access(0, 1, 32'h48, 32'h0, 3);
        chk("t2_word", data_o, 32'hDEAD_BEEF);

        access(0, 1, 32'h148, 32'h0, 4);
        chk("t3_wb_word", wb_data[95:64], 32'hDEAD_BEEF);

        access(1, 1, 32'h4C, 32'hA5A5_A5A5, 2);
        access(0, 1, 32'h4C, 32'h0, 2);
        chk("t4_word", data_o, 32'hA5A5_A5A5);

        mem_lat = 30;
        @(negedge clk);
        rd_i = 1'b1; addr_i = 32'h2A0;
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (!mem_rd_o && w < 10);
        chk("t5_rd_up", mem_rd_o, 1);
        @(negedge clk);
        rst = 1'b1; rd_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_rd_drop", mem_rd_o, 0);
        chk("t5_ack", ack_o, 0);
        chk("t5_we", mem_we_o, 0);
        for (int i = 0; i < 8; i++) begin
            m_vld[i] = 0; m_dirty[i] = 0;
        end
        access(0, 1, 32'h4C, 32'h0, 3);

        stable_ok = 1'b1;
        access(1, 0, 32'h3A8, 32'h0BAD_F00D, 2);
        access(0, 1, 32'h1A8, 32'h0, 20);
        chk("t6_stable", stable_ok, 1);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            int op;
            a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5)
               | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            op = $urandom_range(0, 3);
            access(op != 0 && op != 1, op != 2, a, $urandom, $urandom_range(1, 6));
        end
        chk("stable_all", stable_ok, 1);
        chk("strobe_excl", excl_ok, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
